tail_light_ctrl: RTL and testbench
==================================

Name: tail_light_ctrl

Overview:
Sequencing controller for the six-lamp rear tail-light bank. It synchronizes the driver requests for left, right, hazard and brake, and arbitrates them into one operating mode. It steps a progressive turn pattern at a prescaled rate and drives the registered active-low lamp vector. It sits between the switch inputs and the board LEDs and includes its own step-rate generator.

Parameters:
DIV_W, 24, prescaler width; one pattern step every 2^DIV_W clk cycles (bench uses 2).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
l    in  1  left-turn request, asynchronous to clk
r    in  1  right-turn request, asynchronous to clk
haz  in  1  hazard request, asynchronous to clk
brk  in  1  brake request, asynchronous to clk
led  out 6  lamps, active-low (1 = off); [5:3] left bank, [2:0] right bank; led[3] and led[2] are the innermost lamps
state out 2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - led = 6'b111111, state = IDLE
  - step = 0, prescaler = 0, all synchronizer flops = 0
- Synchronizers: l, r, haz and brk each pass through 2 flops.
  - Input stable before edge E0 reaches sync2 at E1.
  - state/step update at E2; led updates at E3.
- Mode decode from synchronized inputs, priority order:
  - haz, or (l & r) -> HAZARD
  - else l -> LEFT
  - else r -> RIGHT
  - else IDLE
- FSM: state loads the decode result on every edge; it does not wait for a tick.
  - On any state change: step <= 0 and prescaler <= 0 in the same edge.
  - State change beats a coincident tick.
- Prescaler:
  - DIV_W-bit up-counter, wraps to 0.
  - tick = 1 while the counter is all-ones, a 1-cycle pulse.
- step: 2-bit counter.
  - Increments on tick in LEFT, RIGHT and HAZARD; wraps 3->0.
  - Held at 0 in IDLE.
  - After a state change, the first increment occurs at the 2^DIV_W-th edge.
- Turn pattern, per step (bank lamps listed outer to inner):
  - step0: all off
  - step1: inner lamp on
  - step2: inner two lamps on
  - step3: all three on
- Resulting bank values:
  - Left led[5:3]: 111, 110, 100, 000
  - Right led[2:0]: 111, 011, 001, 000
- led, registered from the current state/step/brk_sync:
  - IDLE: 111111, or 000000 when brk.
  - LEFT: left bank follows the pattern. Right bank = 111, or 000 when brk.
  - RIGHT: right bank follows the pattern. Left bank = 111, or 000 when brk.
  - HAZARD: step even -> 111111, step odd -> 000000. brk is ignored.
- Request pulses shorter than one clk may be lost; no latching of requests.
- Reset asserted mid-sequence aborts immediately. After release, the block resumes from IDLE at step 0.

Decomposition:
- Package tail_light_pkg:
  - mode encoding (IDLE/LEFT/RIGHT/HAZARD)
  - BANK_OFF = 3'b111, BANK_ON = 3'b000
  - left and right 4-entry pattern tables
- Sub-module step_tick_gen:
  - contains the DIV_W prescaler
  - ports: clk, rst, clr, tick
- Synchronizers and FSM stay in the top module.

Test Plan:
1. Reset and idle: rst=0 -> led=111111 and state=0 without a clock edge. Release rst with all inputs 0 for 20 clks -> led stays 111111.
2. Right turn (DIV_W=2): r=1 held -> state=2 at E2, led=111111 at E3. Then right bank 011, 001, 000, 111 repeating, each held 4 clks; left bank constant 111.
3. Left turn with brake: l=1, brk=1 -> left bank cycles 111, 110, 100, 000 every 4 clks; right bank constant 000.
4. Hazard: l=1 and r=1 (also haz=1 alone) -> state=3; led alternates 111111 and 000000 every 4 clks. Toggling brk causes no change.
5. Mode switch: r=1 until right bank=001, then r=0 and l=1 -> state=1 two clks later, led=111111 next clk. Left sequence restarts from step0 with a full 4-clk period; right bank = 111.
6. Async reset mid-sequence: with led=000111, pulse rst=0 between edges -> led=111111 and state=0 immediately. After release, hold l=1 -> left sequence restarts at step0.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared mode encoding, bank constants and turn-pattern tables for the
// rear tail-light controller.
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  localparam logic [2:0] BANK_OFF = 3'b111;
  localparam logic [2:0] BANK_ON  = 3'b000;

  // Indexed by step; lamps are active-low and fill from the inner lamp outward.
  localparam logic [3:0][2:0] LEFT_PAT  = {3'b000, 3'b100, 3'b110, 3'b111};
  localparam logic [3:0][2:0] RIGHT_PAT = {3'b000, 3'b001, 3'b011, 3'b111};

  function automatic mode_e decode_mode(input logic left, input logic right,
                                        input logic hazard);
    mode_e m;
    if (hazard || (left && right)) begin
      m = MODE_HAZARD;
    end else if (left) begin
      m = MODE_LEFT;
    end else if (right) begin
      m = MODE_RIGHT;
    end else begin
      m = MODE_IDLE;
    end
    return m;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Free-running prescaler producing a one-cycle step tick every 2^DIV_W clocks;
// clr restarts the period so a new mode always gets a full first step.
module step_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/tail_light_ctrl.sv
// Rear tail-light sequencer: synchronizes driver requests, arbitrates a mode,
// steps the turn pattern at the prescaled rate and registers the lamp vector.
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l,
  input  logic       r,
  input  logic       haz,
  input  logic       brk,
  output logic [5:0] led,
  output logic [1:0] state
);

  logic [3:0] req;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic       l_s, r_s, haz_s, brk_s;

  mode_e      state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [5:0] led_q, led_d;
  logic       state_chg;
  logic       tick;
  logic [2:0] brake_bank;

  assign req   = {brk, haz, r, l};
  assign l_s   = sync2_q[0];
  assign r_s   = sync2_q[1];
  assign haz_s = sync2_q[2];
  assign brk_s = sync2_q[3];

  step_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_chg),
    .tick(tick)
  );

  always_comb begin
    state_d    = decode_mode(l_s, r_s, haz_s);
    state_chg  = (state_d != state_q);
    brake_bank = brk_s ? BANK_ON : BANK_OFF;

    // A mode change restarts the pattern even if a tick lands on the same edge.
    step_d = step_q;
    if (state_chg || (state_q == MODE_IDLE)) begin
      step_d = 2'd0;
    end else if (tick) begin
      step_d = step_q + 2'd1;
    end

    led_d = {BANK_OFF, BANK_OFF};
    case (state_q)
      MODE_IDLE:   led_d = {brake_bank, brake_bank};
      MODE_LEFT:   led_d = {LEFT_PAT[step_q], brake_bank};
      MODE_RIGHT:  led_d = {brake_bank, RIGHT_PAT[step_q]};
      MODE_HAZARD: led_d = step_q[0] ? {BANK_ON, BANK_ON} : {BANK_OFF, BANK_OFF};
      default:     led_d = {BANK_OFF, BANK_OFF};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= MODE_IDLE;
      step_q  <= 2'd0;
      led_q   <= {BANK_OFF, BANK_OFF};
    end else begin
      sync1_q <= req;
      sync2_q <= sync1_q;
      state_q <= state_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign state = state_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Self-checking bench for tail_light_ctrl with a 4-clock step period.
module tb_tail_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       l   = 1'b0;
  logic       r   = 1'b0;
  logic       haz = 1'b0;
  logic       brk = 1'b0;
  logic [5:0] led;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0] led;
    logic [1:0] state;
    string      tag;
  } exp_t;

  typedef struct {
    logic       l;
    logic       r;
    logic       haz;
    logic       brk;
    logic [1:0] mode;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  // Bank values as listed in the lamp table (active-low).
  localparam logic [2:0] LP[4] = '{3'b111, 3'b110, 3'b100, 3'b000};
  localparam logic [2:0] RP[4] = '{3'b111, 3'b011, 3'b001, 3'b000};

  tail_light_ctrl #(
    .DIV_W(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .l    (l),
    .r    (r),
    .haz  (haz),
    .brk  (brk),
    .led  (led),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] exp_led(input logic [1:0] mode, input int s,
                                         input logic b);
    logic [2:0] bb;
    bb = b ? 3'b000 : 3'b111;
    case (mode)
      2'd0:    return b ? 6'b000000 : 6'b111111;
      2'd1:    return {LP[s], bb};
      2'd2:    return {bb, RP[s]};
      default: return ((s % 2) == 1) ? 6'b000000 : 6'b111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req_v);
    end
  endtask

  // Expected outputs after each of the next n edges once new inputs are driven:
  // state follows two edges later, led one edge after that, then 4 clocks per step.
  task automatic push_seq(input logic [1:0] old_state, input logic [5:0] old_led,
                          input logic [1:0] mode, input logic b, input int n,
                          input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.state = (k < 2) ? old_state : mode;
      e.led   = (k < 3) ? old_led : exp_led(mode, ((k - 3) / 4) % 4, b);
      e.tag   = $sformatf("%s[%0d]", tag, k);
      sb.push_back(e);
    end
  endtask

  task automatic run_check(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation, expected one queued");
      end else begin
        e = sb.pop_front();
        chk({e.tag, ".led"}, led, e.led);
        chk({e.tag, ".state"}, {4'b0000, state}, {4'b0000, e.state});
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, "right"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, "left_brk"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, "l_and_r"};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, "haz"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, "haz_brk"};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "idle_brk"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, "haz_and_l"};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, "right_brk"};

    // Reset takes effect between clock edges.
    #2 rst = 1'b0;
    #1;
    chk("rst_async.led", led, 6'b111111);
    chk("rst_async.state", {4'b0000, state}, 6'd0);
    #20 rst = 1'b1;
    @(posedge clk);
    #1;
    push_seq(2'd0, 6'b111111, 2'd0, 1'b0, 20, "idle");
    run_check(20);
    $display("[TB] idle after reset done");

    foreach (vecs[i]) begin
      l   = 1'b0;
      r   = 1'b0;
      haz = 1'b0;
      brk = vecs[i].brk;
      wait_cycles(6);
      e.led   = exp_led(2'd0, 0, vecs[i].brk);
      e.state = 2'd0;
      e.tag   = {vecs[i].name, ".pre"};
      sb.push_back(e);
      run_check(1);
      l   = vecs[i].l;
      r   = vecs[i].r;
      haz = vecs[i].haz;
      push_seq(2'd0, exp_led(2'd0, 0, vecs[i].brk), vecs[i].mode, vecs[i].brk, 20,
               vecs[i].name);
      run_check(20);
      $display("[TB] vector %0d %s l=%b r=%b haz=%b brk=%b mode=%0d", i, vecs[i].name,
               vecs[i].l, vecs[i].r, vecs[i].haz, vecs[i].brk, vecs[i].mode);
    end

    // Hazard with brake toggling underneath: lamps must not react to brk.
    l = 1'b0; r = 1'b0; haz = 1'b0; brk = 1'b0;
    wait_cycles(6);
    l = 1'b1; r = 1'b1;
    push_seq(2'd0, 6'b111111, 2'd3, 1'b0, 20, "haz_brk_toggle");
    for (int j = 0; j < 20; j++) begin
      run_check(1);
      if (j >= 3 && (j % 3) == 0) brk = ~brk;
    end
    $display("[TB] hazard with brake toggling done");

    // Right turn interrupted by left at right bank 001.
    l = 1'b0; r = 1'b0; haz = 1'b0; brk = 1'b0;
    wait_cycles(6);
    r = 1'b1;
    push_seq(2'd0, 6'b111111, 2'd2, 1'b0, 12, "sw_right");
    run_check(12);
    r = 1'b0;
    l = 1'b1;
    push_seq(2'd2, 6'b111001, 2'd1, 1'b0, 16, "sw_left");
    run_check(16);
    $display("[TB] right-to-left switch done");

    // Reset pulse between edges while left bank is fully lit.
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.led", led, 6'b111111);
    chk("rst_mid.state", {4'b0000, state}, 6'd0);
    #1 rst = 1'b1;
    push_seq(2'd0, 6'b111111, 2'd1, 1'b0, 12, "post_reset");
    run_check(12);
    $display("[TB] mid-sequence reset done");

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
